// File: rtl/lsu_pkg.sv
// lsu_pkg: shared widths, store-buffer state encoding and entry layout.
package lsu_pkg;
    localparam int ADDR_W   = 24;
    localparam int DATA_W   = 24;
    localparam int RAM_AW   = 18;
    localparam int RAM_DW   = 16;
    localparam int SB_DEPTH = 4;
    typedef enum logic {RUN, FLUSH} sb_state_t;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;
endpackage

// File: rtl/store_fifo_cam.sv
// store_fifo_cam: circular store FIFO with a youngest-match lookup on the RAM address bits.
module store_fifo_cam
    import lsu_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic [RAM_AW-1:0] lookup_addr,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [CW-1:0]     count,
    output logic              hit,
    output logic [RAM_DW-1:0] hit_data
);
    sb_entry_t      mem_q [DEPTH];
    logic [PW-1:0]  rd_q, wr_q;
    logic [CW-1:0]  count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= '{addr: push_addr, data: push_data};
    end

    assign head_addr = mem_q[rd_q].addr;
    assign head_data = mem_q[rd_q].data;
    assign count     = count_q;

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q && mem_q[rd_q + PW'(i)].addr[RAM_AW-1:0] == lookup_addr) begin
                hit      = 1'b1;
                hit_data = mem_q[rd_q + PW'(i)].data[RAM_DW-1:0];
            end
        end
    end
endmodule

// File: rtl/mem_store_buffer.sv
// mem_store_buffer: store buffer with load forwarding, idle-cycle drain and a flush FSM
// arbitrating a single data-memory port.
module mem_store_buffer
    import lsu_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              flush_req,
    output logic              stall,
    output logic              load_valid,
    output logic [DATA_W-1:0] load_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_writeenable,
    output logic              mem_MemRead,
    input  logic [DATA_W-1:0] mem_data
);
    localparam int CW = $clog2(DEPTH) + 1;

    sb_state_t         state_q, state_d;
    logic [CW-1:0]     count;
    logic              hit;
    logic [RAM_DW-1:0] hit_data;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              run, empty, full, st, ld, miss, drain;
    logic              load_valid_q, load_valid_d;
    logic [DATA_W-1:0] load_data_q, load_data_d;

    store_fifo_cam #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (st),
        .pop        (drain),
        .push_addr  (req_addr),
        .push_data  (req_wdata),
        .lookup_addr(req_addr[RAM_AW-1:0]),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .count      (count),
        .hit        (hit),
        .hit_data   (hit_data)
    );

    // Idle drain is skipped while flush_req is raised so the whole buffer drains inside FLUSH.
    always_comb begin
        run          = state_q == RUN;
        empty        = count == '0;
        full         = count == CW'(DEPTH);
        st           = run & req_valid & req_write;
        ld           = run & req_valid & ~req_write;
        miss         = ld & ~hit;
        drain        = ~empty & (~run | (st & full) | (~req_valid & ~flush_req));
        state_d      = run ? ((flush_req & ~empty) ? FLUSH : RUN) : ((count == CW'(1)) ? RUN : FLUSH);
        load_valid_d = ld;
        load_data_d  = ld ? (hit ? {{(DATA_W-RAM_DW){1'b0}}, hit_data} : mem_data) : load_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            load_valid_q <= 1'b0;
            load_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            load_valid_q <= load_valid_d;
            load_data_q  <= load_data_d;
        end
    end

    // Gating with rst keeps a reset cycle from writing buffered stores to memory.
    assign stall           = ~run & ~rst;
    assign mem_writeenable = drain & ~rst;
    assign mem_MemRead     = miss & ~rst;
    assign mem_address     = mem_writeenable ? head_addr : (mem_MemRead ? req_addr : '0);
    assign mem_writedata   = mem_writeenable ? head_data : '0;
    assign load_valid      = load_valid_q;
    assign load_data       = load_data_q;
endmodule
